// File: rtl/coinc_gate_if.sv
// Bundle of the coincidence-gate controls and results, shared by the gate (slave) and its driver (master).
// With COINC_COUNTER_EN defined it also carries the fire counter and its clear.
interface coinc_gate_if #(
   parameter int N_CH   = 4,
   parameter int WIN_W  = 8,
   parameter int DEAD_W = 8,
   parameter int CNT_W  = 32
);
   localparam int TH_W = $clog2(N_CH + 1);

   logic              enable;
   logic [N_CH-1:0]   ch_in;
   logic [N_CH-1:0]   ch_mask;
   logic [TH_W-1:0]   threshold;
   logic [WIN_W-1:0]  window;
   logic [DEAD_W-1:0] deadtime;
   logic              coinc_out;
   logic [N_CH-1:0]   coinc_pattern;
   logic              busy;

`ifdef COINC_COUNTER_EN
   logic              cnt_clr;
   logic [CNT_W-1:0]  coinc_count;

   modport master (
      output enable, ch_in, ch_mask, threshold, window, deadtime, cnt_clr,
      input  coinc_out, coinc_pattern, busy, coinc_count
   );

   modport slave (
      input  enable, ch_in, ch_mask, threshold, window, deadtime, cnt_clr,
      output coinc_out, coinc_pattern, busy, coinc_count
   );
`else
   logic unused_cnt_cfg;
   assign unused_cnt_cfg = ^CNT_W;

   modport master (
      output enable, ch_in, ch_mask, threshold, window, deadtime,
      input  coinc_out, coinc_pattern, busy
   );

   modport slave (
      input  enable, ch_in, ch_mask, threshold, window, deadtime,
      output coinc_out, coinc_pattern, busy
   );
`endif
endinterface

// File: rtl/coinc_gate_n.sv
// N-channel k-of-N coincidence gate: per-channel window stretchers, dead-time hold-off, pattern capture.
// Optional fire counter (coinc_count / cnt_clr) is built when COINC_COUNTER_EN is defined.
module coinc_gate_n #(
   parameter int N_CH   = 4,
   parameter int WIN_W  = 8,
   parameter int DEAD_W = 8,
   parameter int CNT_W  = 32
) (
   input logic         clk,
   input logic         rst_n,
   coinc_gate_if.slave bus
);
   localparam int TH_W = $clog2(N_CH + 1);

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      FIRE  = 2'd1,
      DEAD  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [N_CH-1:0]   ch_d_p0;
   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   active;
   logic [WIN_W-1:0]  win_cnt [N_CH];
   logic [DEAD_W-1:0] dcnt;
   logic [TH_W-1:0]   sum;
   logic [N_CH-1:0]   pattern_p1;
   logic              hit;
   logic              fire;

   function automatic logic [TH_W-1:0] popcount(input logic [N_CH-1:0] v);
      logic [TH_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_CH; i++) c = c + TH_W'(v[i]);
      return c;
   endfunction

   // A zero window still gives a one-cycle active pulse.
   function automatic logic [WIN_W-1:0] win_load(input logic [WIN_W-1:0] w);
      return (w == '0) ? '0 : w - 1'b1;
   endfunction

   // Stage 0: edge detect against the registered channel levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ch_d_p0 <= '0;
      else        ch_d_p0 <= bus.ch_in;
   end

   assign rise = bus.ch_in & ~ch_d_p0 & bus.ch_mask & {N_CH{bus.enable}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) win_cnt[i] <= '0;
      end else if (!bus.enable || fire) begin
         for (int i = 0; i < N_CH; i++) win_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (rise[i])                win_cnt[i] <= win_load(bus.window);
            else if (win_cnt[i] != '0) win_cnt[i] <= win_cnt[i] - 1'b1;
         end
      end
   end

   always_comb begin
      active = '0;
      for (int i = 0; i < N_CH; i++) active[i] = rise[i] | (win_cnt[i] != '0);
   end

   assign sum  = popcount(active);
   assign hit  = (bus.threshold != '0) && (sum >= bus.threshold);
   assign fire = bus.enable && (state == ARMED) && hit;

   // Stage 1: fire state, hold-off counter and captured pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARMED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!bus.enable) begin
         state_nxt = ARMED;
      end else begin
         case (state)
            ARMED:   if (hit) state_nxt = FIRE;
            FIRE:    state_nxt = (bus.deadtime == '0) ? ARMED : DEAD;
            DEAD:    if (dcnt == '0) state_nxt = ARMED;
            default: state_nxt = ARMED;
         endcase
      end
   end

   always_comb begin
      bus.coinc_out = (state == FIRE);
      bus.busy      = (state != ARMED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dcnt <= '0;
      else if (!bus.enable)
         dcnt <= '0;
      else if (state == FIRE && bus.deadtime != '0)
         dcnt <= bus.deadtime - 1'b1;
      else if (state == DEAD && dcnt != '0)
         dcnt <= dcnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pattern_p1 <= '0;
      else if (fire) pattern_p1 <= active;
   end

   assign bus.coinc_pattern = pattern_p1;

`ifdef COINC_COUNTER_EN
   logic [CNT_W-1:0] count_p1;

   // Clear takes priority over a fire in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           count_p1 <= '0;
      else if (bus.cnt_clr) count_p1 <= '0;
      else if (fire)        count_p1 <= count_p1 + 1'b1;
   end

   assign bus.coinc_count = count_p1;
`else
   logic unused_cnt_cfg;
   assign unused_cnt_cfg = ^CNT_W;
`endif
endmodule
